// File: rtl/seg_scan_driver.sv
// Scan controller for a common-anode multi-digit seven-segment display; updates commit on frame wrap.
// Optional leading-zero blanking of the anodes: define SEG_SCAN_LEADING_ZERO_BLANK_EN.
module seg_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [3:0]            num_out,
    output logic [DIGITS-1:0]     an,
    output logic                  dp_out,
    output logic                  frame_start,
    output logic                  busy
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    prescaler;
    logic [IDX_W-1:0]    digit_idx;
    logic [4*DIGITS-1:0] staging;
    logic [4*DIGITS-1:0] shadow;
    logic                pending;
    logic                tick;
    logic                wrap;
    logic                lit;
    logic [DIGITS-1:0]   onehot;

    assign tick   = en && (prescaler == CNT_LAST);
    assign wrap   = tick && (digit_idx == IDX_LAST);
    assign onehot = DIGITS'(1) << digit_idx;
    assign busy   = pending;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd;

    // Highest nonzero nibble; stays 0 for an all-zero value so digit 0 always lights.
    always_comb begin
        msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (shadow[i*4 +: 4] != 4'h0) begin
                msd = IDX_W'(i);
            end
        end
    end

    assign lit = (digit_idx <= msd);
`else
    assign lit = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            digit_idx <= '0;
        end else if (tick) begin
            prescaler <= '0;
            digit_idx <= wrap ? '0 : digit_idx + IDX_W'(1);
        end else if (en) begin
            prescaler <= prescaler + CNT_W'(1);
        end
    end

    // A load coinciding with the commit edge lands in staging after the old staging is committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            if (wrap && pending) begin
                shadow <= staging;
            end
            if (load) begin
                staging <= value;
            end
            pending <= load | (pending & ~wrap);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_out     <= 4'h0;
            an          <= '1;
            dp_out      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            num_out     <= shadow[{digit_idx, 2'b00} +: 4];
            an          <= (en && lit) ? ~onehot : '1;
            dp_out      <= en ? ~dp_mask[digit_idx] : 1'b1;
            frame_start <= wrap;
        end
    end

endmodule
